// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction encoding, the opposite-direction
// rule used by both the keypad front end and the snake core, and the keypad FSM states.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Flipping the upper bit of a direction yields its 180-degree opposite.
  localparam logic [1:0] DIR_FLIP  = 2'b10;

  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ DIR_FLIP;
  endfunction

  typedef enum logic [1:0] {
    KD_IDLE,
    KD_PRESS_DB,
    KD_HELD,
    KD_REL_DB
  } kd_state_t;

endpackage

// File: rtl/dir_fifo2.sv
// Two-entry, 2-bit direction FIFO. The head entry is held in its own register so
// rd_data is registered; the second entry sits behind it and shifts forward on a pop.
module dir_fifo2
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_data,
  input  logic       rd_en,
  output logic [1:0] rd_data,
  output logic       empty,
  output logic       full
);

  logic [1:0] head_q;
  logic [1:0] tail_q;
  logic [1:0] count_q;
  logic       do_rd;
  logic       do_wr;

  // A pop on an empty FIFO is ignored; a push when full is only taken alongside a pop.
  assign do_rd   = rd_en && (count_q != 2'd0);
  assign do_wr   = wr_en && ((count_q != 2'd2) || do_rd);
  assign rd_data = head_q;
  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);

  // Storage and occupancy update for push, pop, or both in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the two entries are reset as well, so the head reads a defined UP after reset.
      head_q  <= DIR_UP;
      tail_q  <= DIR_UP;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments, so every branch sees the pre-edge head/tail/count.
      unique case ({do_wr, do_rd})
        2'b10: begin
          if (count_q == 2'd0) head_q <= wr_data;
          else                 tail_q <= wr_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_q <= wr_data;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_dir_ctrl.sv
// Keypad front end for the snake game: turns raw scanner samples into one debounced
// event per physical press, filters direction reversals, and queues directions in a
// 2-entry FIFO. The pause key yields a single-cycle toggle pulse.
module keypad_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = 8,
  parameter logic [3:0]  CODE_UP    = 4'h2,
  parameter logic [3:0]  CODE_LEFT  = 4'h5,
  parameter logic [3:0]  CODE_RIGHT = 4'h7,
  parameter logic [3:0]  CODE_DOWN  = 4'ha,
  parameter logic [3:0]  CODE_PAUSE = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_clk,
  input  logic       keydown,
  input  logic [3:0] code,
  output logic       dir_valid,
  output logic [1:0] dir,
  input  logic       dir_ready,
  output logic       pause_pulse,
  output logic       overflow
);

  localparam logic [7:0] DB_TICKS = 8'(DEBOUNCE);

  logic       scan_q;
  logic       tick;
  kd_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic       accept;
  logic       acc_pause;
  logic       acc_is_dir;
  logic [1:0] acc_dir;
  logic       ev_valid_q;
  logic [1:0] ev_dir_q;
  logic [1:0] last_dir_q;
  logic       dir_new;
  logic       fifo_wr;
  logic       fifo_empty;
  logic       fifo_full;

  // Previous scan_clk level, for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) scan_q <= 1'b0;
    else      scan_q <= scan_clk;
  end

  assign tick = scan_clk & ~scan_q;

  // Debounce FSM registers: state, stable-tick counter and candidate code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= KD_IDLE;
      cnt_q   <= 8'd0;
      cand_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Debounce next-state logic; it only advances on scan ticks.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (tick) begin
      unique case (state_q)
        KD_IDLE: begin
          if (keydown) begin
            cand_d = code;
            cnt_d  = 8'd1;
            if (DB_TICKS <= 8'd1) begin
              accept  = 1'b1;
              state_d = KD_HELD;
            end else begin
              state_d = KD_PRESS_DB;
            end
          end
        end
        KD_PRESS_DB: begin
          if (keydown && (code == cand_q)) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d >= DB_TICKS) begin
              accept  = 1'b1;
              state_d = KD_HELD;
            end
          end else begin
            cnt_d   = 8'd0;
            state_d = KD_IDLE;
          end
        end
        KD_HELD: begin
          // Code changes while held are ignored: no autorepeat.
          if (!keydown) begin
            cnt_d   = 8'd1;
            state_d = (DB_TICKS <= 8'd1) ? KD_IDLE : KD_REL_DB;
          end
        end
        KD_REL_DB: begin
          if (keydown) begin
            state_d = KD_HELD;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d >= DB_TICKS) state_d = KD_IDLE;
          end
        end
        default: state_d = KD_IDLE;
      endcase
    end
  end

  // Map the accepted code to an action, PAUSE > UP > RIGHT > DOWN > LEFT on collisions.
  always_comb begin
    acc_pause  = 1'b0;
    acc_is_dir = 1'b1;
    acc_dir    = DIR_UP;
    if (cand_d == CODE_PAUSE) begin
      acc_pause  = 1'b1;
      acc_is_dir = 1'b0;
    end else if (cand_d == CODE_UP) begin
      acc_dir = DIR_UP;
    end else if (cand_d == CODE_RIGHT) begin
      acc_dir = DIR_RIGHT;
    end else if (cand_d == CODE_DOWN) begin
      acc_dir = DIR_DOWN;
    end else if (cand_d == CODE_LEFT) begin
      acc_dir = DIR_LEFT;
    end else begin
      acc_is_dir = 1'b0;
    end
  end

  // A direction is new only if it neither repeats nor reverses the last enqueued one.
  assign dir_new = ev_valid_q && (ev_dir_q != last_dir_q)
                              && (ev_dir_q != dir_opposite(last_dir_q));
  // A full FIFO still takes the entry when the consumer pops in the same cycle.
  assign fifo_wr = dir_new && (!fifo_full || dir_ready);

  // Registered accept events, reversal-filter memory and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_pulse <= 1'b0;
      ev_valid_q  <= 1'b0;
      ev_dir_q    <= DIR_UP;
      last_dir_q  <= DIR_RIGHT;
      overflow    <= 1'b0;
    end else begin
      pause_pulse <= accept && acc_pause;
      ev_valid_q  <= accept && acc_is_dir;
      ev_dir_q    <= acc_dir;
      if (fifo_wr) last_dir_q <= ev_dir_q;
      if (dir_new && !fifo_wr) overflow <= 1'b1;
    end
  end

  dir_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (ev_dir_q),
    .rd_en   (dir_ready),
    .rd_data (dir),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign dir_valid = ~fifo_empty;

endmodule

// File: tb/tb_keypad_dir_ctrl.sv
// Bench for keypad_dir_ctrl: directed scenarios plus randomized press/release
// sequences, all compared against a behavioural model of the keypad rules.
module tb_keypad_dir_ctrl;

  localparam int DEBOUNCE = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_clk;
  logic       keydown;
  logic [3:0] code;
  logic       dir_valid;
  logic [1:0] dir;
  logic       dir_ready;
  logic       pause_pulse;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  keypad_dir_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .scan_clk    (scan_clk),
    .keydown     (keydown),
    .code        (code),
    .dir_valid   (dir_valid),
    .dir         (dir),
    .dir_ready   (dir_ready),
    .pause_pulse (pause_pulse),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Pause pulse monitor: cycles high and separate pulses seen.
  int   pulse_cycles = 0;
  int   pulse_edges  = 0;
  logic pulse_prev   = 1'b0;
  always @(negedge clk) begin
    if (pause_pulse === 1'b1) begin
      pulse_cycles++;
      if (pulse_prev !== 1'b1) pulse_edges++;
    end
    pulse_prev = pause_pulse;
  end

  // ---------------- behavioural model ----------------
  logic [1:0] m_q[$];
  logic [1:0] m_last;
  bit         m_ovf;
  bit         m_held;
  int         m_run;
  logic [3:0] m_cand;
  int         m_pulses = 0;
  logic       vld_trace[4];

  // 4 = pause, 0..3 = UP/RIGHT/DOWN/LEFT, -1 = no effect.
  function automatic int classify(input logic [3:0] c);
    if (c == 4'h0) return 4;
    if (c == 4'h2) return 0;
    if (c == 4'h7) return 1;
    if (c == 4'ha) return 2;
    if (c == 4'h5) return 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last = 2'd1;
    m_ovf  = 1'b0;
    m_held = 1'b0;
    m_run  = 0;
    m_cand = 4'h0;
  endtask

  // Debounce rule: DEBOUNCE identical pressed ticks starting from idle accept a key;
  // DEBOUNCE consecutive released ticks end the hold.
  task automatic model_tick(input logic kd, input logic [3:0] c, output bit acc);
    acc = 1'b0;
    if (!m_held) begin
      if (m_run == 0) begin
        if (kd) begin m_cand = c; m_run = 1; end
      end else if (kd && c == m_cand) begin
        m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= DEBOUNCE) begin acc = 1'b1; m_held = 1'b1; m_run = 0; end
    end else begin
      if (!kd) m_run++;
      else     m_run = 0;
      if (m_run >= DEBOUNCE) begin m_held = 1'b0; m_run = 0; end
    end
  endtask

  task automatic model_accept(input logic [3:0] c);
    int k;
    logic [1:0] d;
    k = classify(c);
    if (k == 4) begin
      m_pulses++;
    end else if (k >= 0) begin
      d = 2'(k);
      if (k == int'(m_last) || k == (int'(m_last) + 2) % 4) begin
        // redundant or reversing: discarded
      end else if (m_q.size() == 2) begin
        m_ovf = 1'b1;
      end else begin
        m_q.push_back(d);
        m_last = d;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  // One scan tick spans four clk cycles; any resulting FIFO write has settled by the end.
  task automatic drive_tick(input logic kd, input logic [3:0] c, input bit pop_w);
    bit         acc;
    logic       pv;
    logic [1:0] pd;
    logic       exp_v;
    pv = 1'b0;
    pd = 2'b00;
    keydown  = kd;
    code     = c;
    scan_clk = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      if (e == 3) scan_clk = 1'b0;
      if (pop_w && e == 2) begin
        dir_ready = 1'b1;
        pv = dir_valid;
        pd = dir;
      end else begin
        dir_ready = 1'b0;
      end
      @(posedge clk);
      #1 vld_trace[e-1] = dir_valid;
      @(negedge clk);
    end
    dir_ready = 1'b0;
    model_tick(kd, c, acc);
    if (pop_w) begin
      exp_v = (m_q.size() != 0);
      n_checks++;
      if (pv !== exp_v) begin
        n_errors++;
        $display("FAIL tick_pop_valid: got %b expected %b", pv, exp_v);
      end
      if (m_q.size() != 0) begin
        n_checks++;
        if (pd !== m_q[0]) begin
          n_errors++;
          $display("FAIL tick_pop_dir: got %b expected %b", pd, m_q[0]);
        end
        void'(m_q.pop_front());
      end
    end
    if (acc) model_accept(m_cand);
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int rel);
    for (int i = 0; i < hold; i++) drive_tick(1'b1, c, 1'b0);
    for (int i = 0; i < rel; i++)  drive_tick(1'b0, c, 1'b0);
  endtask

  task automatic expect_outputs(input string name);
    logic exp_v;
    exp_v = (m_q.size() != 0);
    n_checks++;
    if (dir_valid !== exp_v) begin
      n_errors++;
      $display("FAIL %s dir_valid: got %b expected %b", name, dir_valid, exp_v);
    end
    if (m_q.size() != 0) begin
      n_checks++;
      if (dir !== m_q[0]) begin
        n_errors++;
        $display("FAIL %s dir: got %b expected %b", name, dir, m_q[0]);
      end
    end
    n_checks++;
    if (overflow !== m_ovf) begin
      n_errors++;
      $display("FAIL %s overflow: got %b expected %b", name, overflow, m_ovf);
    end
    n_checks++;
    if (pulse_cycles != m_pulses || pulse_edges != m_pulses) begin
      n_errors++;
      $display("FAIL %s pause_pulse: got %0d cycles/%0d pulses expected %0d",
               name, pulse_cycles, pulse_edges, m_pulses);
    end
  endtask

  // Pop one entry (or attempt a pop on an empty FIFO), checking the head first.
  task automatic pop_one(input string name);
    expect_outputs(name);
    dir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dir_ready = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b0;
    scan_clk  = 1'b0;
    keydown   = 1'b0;
    code      = 4'h0;
    dir_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (dir_valid !== 1'b0 || dir !== 2'b00 || pause_pulse !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got valid=%b dir=%b pause=%b ovf=%b expected 0/00/0/0",
               name, dir_valid, dir, pause_pulse, overflow);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; scan_clk = 1'b0; keydown = 1'b0; code = 4'h0; dir_ready = 1'b0;
    #12;
    check_reset_outputs("reset_hold");
    apply_reset();
    check_reset_outputs("reset_release");
    expect_outputs("reset_model");
  endtask

  task automatic test_single_up();
    apply_reset();
    for (int i = 0; i < DEBOUNCE - 1; i++) drive_tick(1'b1, 4'h2, 1'b0);
    drive_tick(1'b1, 4'h2, 1'b0);
    n_checks++;
    if ({vld_trace[0], vld_trace[1], vld_trace[2], vld_trace[3]} !== 4'b0111) begin
      n_errors++;
      $display("FAIL up_latency: got %b%b%b%b expected 0111",
               vld_trace[0], vld_trace[1], vld_trace[2], vld_trace[3]);
    end
    for (int i = 0; i < DEBOUNCE; i++) drive_tick(1'b0, 4'h2, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b00) begin
      n_errors++;
      $display("FAIL up_event: got valid=%b dir=%b expected 1/00", dir_valid, dir);
    end
    pop_one("up_pop");
    expect_outputs("up_after_pop");
  endtask

  task automatic test_short_press();
    apply_reset();
    press(4'h2, 5, DEBOUNCE);
    n_checks++;
    if (dir_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL short_press: got valid=%b expected 0", dir_valid);
    end
    press(4'h2, DEBOUNCE, DEBOUNCE);
    expect_outputs("after_short");
  endtask

  task automatic test_reversal();
    apply_reset();
    press(4'h5, DEBOUNCE, DEBOUNCE);
    n_checks++;
    if (dir_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reversal_left: got valid=%b expected 0", dir_valid);
    end
    press(4'h2, DEBOUNCE, DEBOUNCE);
    press(4'ha, DEBOUNCE, DEBOUNCE);
    expect_outputs("reversal_model");
    n_checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b00) begin
      n_errors++;
      $display("FAIL reversal_up: got valid=%b dir=%b expected 1/00", dir_valid, dir);
    end
    pop_one("reversal_pop");
    n_checks++;
    if (dir_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reversal_down_dropped: got valid=%b expected 0", dir_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    press(4'h2, DEBOUNCE, DEBOUNCE);
    press(4'h5, DEBOUNCE, DEBOUNCE);
    press(4'h2, DEBOUNCE, DEBOUNCE);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_set: got %b expected 1", overflow);
    end
    n_checks++;
    if (dir !== 2'b00) begin
      n_errors++;
      $display("FAIL overflow_head0: got %b expected 00", dir);
    end
    pop_one("overflow_pop0");
    n_checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b11) begin
      n_errors++;
      $display("FAIL overflow_head1: got valid=%b dir=%b expected 1/11", dir_valid, dir);
    end
    pop_one("overflow_pop1");
    pop_one("overflow_empty_pop");
    expect_outputs("overflow_sticky");
  endtask

  task automatic test_pause();
    int c0;
    apply_reset();
    press(4'h2, DEBOUNCE, DEBOUNCE);
    c0 = pulse_cycles;
    press(4'h0, DEBOUNCE, DEBOUNCE);
    n_checks++;
    if (pulse_cycles - c0 !== 1) begin
      n_errors++;
      $display("FAIL pause_width: got %0d cycles expected 1", pulse_cycles - c0);
    end
    expect_outputs("pause_fifo");
    pop_one("pause_pop");
    expect_outputs("pause_empty");
  endtask

  task automatic test_glitch();
    apply_reset();
    press(4'h2, DEBOUNCE, 2);
    press(4'h7, 6, DEBOUNCE);
    expect_outputs("glitch_model");
    pop_one("glitch_pop");
    n_checks++;
    if (dir_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch_second_event: got valid=%b expected 0", dir_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    press(4'h2, DEBOUNCE, DEBOUNCE);
    press(4'h5, DEBOUNCE, DEBOUNCE);
    for (int i = 0; i < DEBOUNCE - 1; i++) drive_tick(1'b1, 4'ha, 1'b0);
    drive_tick(1'b1, 4'ha, 1'b1);
    press(4'ha, 0, DEBOUNCE);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL push_pop_full_ovf: got %b expected 0", overflow);
    end
    n_checks++;
    if (dir !== 2'b11) begin
      n_errors++;
      $display("FAIL push_pop_full_head: got %b expected 11", dir);
    end
    pop_one("push_pop_full_pop0");
    n_checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b10) begin
      n_errors++;
      $display("FAIL push_pop_full_tail: got valid=%b dir=%b expected 1/10", dir_valid, dir);
    end
    pop_one("push_pop_full_pop1");
    expect_outputs("push_pop_full_end");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press(4'h2, 4, 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset_mid_debounce");
    apply_reset();
    press(4'h2, DEBOUNCE, DEBOUNCE);
    press(4'h5, DEBOUNCE, DEBOUNCE);
    press(4'h2, DEBOUNCE, DEBOUNCE);
    expect_outputs("reset_full_before");
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset_mid_full");
    apply_reset();
    // last direction is back to RIGHT, so LEFT must be dropped as a reversal
    press(4'h5, DEBOUNCE, DEBOUNCE);
    expect_outputs("reset_last_dir");
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic [3:0] codes[6];
    int hold, rel;
    codes = '{4'h2, 4'h5, 4'h7, 4'ha, 4'h0, 4'h0};
    apply_reset();
    for (int p = 0; p < 100; p++) begin
      c = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) c = 4'($urandom_range(0, 15));
      hold = $urandom_range(3, 11);
      rel  = $urandom_range(1, 11);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 9) == 0) drive_tick(1'b1, c ^ 4'($urandom_range(1, 15)), 1'b0);
        else drive_tick(1'b1, c, $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < rel; i++) drive_tick(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      expect_outputs("random");
      for (int k = $urandom_range(0, 2); k > 0; k--) pop_one("random_pop");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_up();
    test_short_press();
    test_reversal();
    test_overflow();
    test_pause();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_dir_ctrl.md
# keypad_dir_ctrl

Sequences the 4x4 keypad scanner output into clean game commands for the snake core. Samples the scanner's `code`/`keydown` on each scan tick, debounces press and release, and emits exactly one event per physical press. Direction keys are filtered against 180° reversals and queued in a 2-entry FIFO drained by the game-tick logic. The pause key produces a single-cycle toggle pulse.

## Interface
- `DEBOUNCE`, default 8: number of consecutive scan ticks a press or release must be stable before it is accepted (1..255).
- `CODE_UP`, default 4'h2: keypad code mapped to UP.
- `CODE_LEFT`, default 4'h5: keypad code mapped to LEFT.
- `CODE_RIGHT`, default 4'h7: keypad code mapped to RIGHT.
- `CODE_DOWN`, default 4'ha: keypad code mapped to DOWN.
- `CODE_PAUSE`, default 4'h0: keypad code mapped to the pause toggle.

Ports:
- `clk`  in  1  system clock (same clock that drives the scanner).
- `rst`  in  1  asynchronous, active-low reset.
- `scan_clk`  in  1  scanner sample clock, a divided copy of `clk`. Edge-detected only; never used as a clock.
- `keydown`  in  1  scanner "any key pressed" flag.
- `code`  in  4  scanner last-key code.
- `dir_valid`  out  1  FIFO head holds a direction.
- `dir`  out  2  head direction: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.
- `dir_ready`  in  1  consumer pops the head this cycle when `dir_valid` is high.
- `pause_pulse`  out  1  single-cycle pulse on an accepted pause press.
- `overflow`  out  1  sticky; set when a direction was dropped because the FIFO was full. Cleared only by reset.

## Operation
- **Scan tick.** A tick is a one-`clk` strobe on each rising edge of `scan_clk`, detected by registering `scan_clk` and comparing with its previous value. All debounce activity advances only on ticks.
- **State machine.** States: IDLE, PRESS_DB, HELD, REL_DB.
  - IDLE: on a tick with `keydown`=1, latch `code` into `cand`, set `cnt`=1, go to PRESS_DB.
  - PRESS_DB: on a tick with `keydown`=1 and `code`==`cand`, increment `cnt`. When `cnt` reaches `DEBOUNCE`, accept the key (below) and go to HELD.
  - PRESS_DB: on a tick with `keydown`=0 or a different code, return to IDLE with no event.
  - HELD: on a tick with `keydown`=0, set `cnt`=1 and go to REL_DB. Code changes while held are ignored, so there is no autorepeat.
  - REL_DB: each tick with `keydown`=0 increments `cnt`; at `DEBOUNCE`, go to IDLE. A tick with `keydown`=1 returns to HELD.
- **Accept.**
  - `cand`==`CODE_PAUSE`: pulse `pause_pulse`.
  - `cand` matches a direction code: run the reversal filter, then enqueue.
  - Any other code: no effect.
  - If a parameter collision exists, priority is PAUSE > UP > RIGHT > DOWN > LEFT.
- **Reversal filter.** `last_dir` holds the most recently enqueued direction and resets to RIGHT.
  - A candidate equal to `last_dir ^ 2'b10` (the opposite direction) is discarded.
  - A candidate equal to `last_dir` is also discarded, since it is redundant.
  - Otherwise the candidate is enqueued and `last_dir` is updated.
- **FIFO.** 2 entries.
  - Enqueue when full: drop the entry, set `overflow`, leave `last_dir` unchanged.
  - Enqueue and pop in the same cycle when full: allowed; occupancy stays 2.
  - Pop with `dir_valid`=0: ignored.

## Timing
- Reset values: state IDLE, `cnt`=0, `dir_valid`=0, `dir`=00, `pause_pulse`=0, `overflow`=0, `last_dir`=01, FIFO empty.
- Press latency: the event is registered in the `clk` cycle after the tick on which `cnt` reaches `DEBOUNCE`. `dir_valid` rises the following cycle, when FIFO `count` becomes nonzero.
- `dir`/`dir_valid` come from registers only. Pop takes effect at the clock edge where `dir_valid`&`dir_ready`.
- `DEBOUNCE`=1: the press is accepted on the first tick after IDLE.
- Asserting reset mid-debounce or with a full FIFO returns every output to its reset value immediately.

## Structure
- Package `snake_pkg` holds:
  - the direction localparams `DIR_UP`=2'b00, `DIR_RIGHT`=2'b01, `DIR_DOWN`=2'b10, `DIR_LEFT`=2'b11;
  - the opposite-direction rule (XOR 2'b10), shared with the snake core.
- Sub-module `dir_fifo2`: a 2-deep, 2-bit-wide synchronous FIFO. Ports: `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`. Registered `rd_data`, async active-low reset.
- FSM, tick detector, debounce counter and reversal filter live in the top module.

## Test plan
- Hold code 4'h2 with `keydown`=1 for 8 ticks, then release for 8 ticks -> exactly one `dir`=00 event; `dir_valid` stays high until `dir_ready`.
- Press 4'h2 for only 5 ticks (`DEBOUNCE`=8) -> no event, state back to IDLE.
- From reset, press LEFT (4'ha mapped LEFT? no: press code 4'h5) -> discarded as the reversal of RIGHT. Then press UP followed by DOWN -> only UP is queued.
- Press UP, LEFT, UP with `dir_ready`=0 -> FIFO holds UP, LEFT; the third press is dropped and `overflow`=1. Pop twice -> UP, then LEFT.
- Press 4'h0 -> `pause_pulse` is high for exactly one `clk` cycle and the FIFO is unchanged.
- Hold a key with a 2-tick release glitch mid-hold -> no second event. Assert `rst` during PRESS_DB -> all outputs return to reset values.
